// File: rtl/ahb_apb_pkg.sv
// Shared AHB/APB bridge types: AMBA encodings, ctrl FIFO entry layout and APB FSM states.
package ahb_apb_pkg;

    localparam int HADDR_W  = 8;
    localparam int PDATA_W  = 32;
    localparam int PSTRB_W  = PDATA_W / 8;
    localparam int CTRL_W   = 1 + 2 + 3 + 3 + HADDR_W;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'b000,
        HSIZE_HALF  = 3'b001,
        HSIZE_WORD  = 3'b010,
        HSIZE_DWORD = 3'b011
    } hsize_e;

    // Ctrl FIFO entry, MSB first: {write, trans, burst, size, addr}.
    typedef struct packed {
        logic               write;
        htrans_e            trans;
        hburst_e            burst;
        hsize_e             size;
        logic [HADDR_W-1:0] addr;
    } ctrl_t;

    typedef enum logic [1:0] {
        P_IDLE   = 2'b00,
        P_SETUP  = 2'b01,
        P_ACCESS = 2'b10
    } apb_state_e;

endpackage

// File: rtl/apb_pstrb_gen.sv
// Byte-lane strobe generator for a 32-bit data path from transfer size and address LSBs.
// Latency: purely combinational, zero cycles.
// Backpressure: none; reads always yield an all-zero strobe.
module apb_pstrb_gen
    import ahb_apb_pkg::*;
(
    input  logic       write,
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] pstrb
);

    always_comb begin
        pstrb = 4'b0000;
        if (write) begin
            case (size)
                HSIZE_BYTE: pstrb = 4'b0001 << addr_lo;
                // Halfwords are lane-aligned: addr[0] does not shift the pair.
                HSIZE_HALF: pstrb = 4'b0011 << {addr_lo[1], 1'b0};
                default:    pstrb = 4'b1111;
            endcase
        end
    end

endmodule

// File: rtl/apb_master.sv
// APB requester for the AHB-to-APB bridge: pops ctrl/wdata FIFOs, runs one APB transfer at a time, pushes read data.
// Latency: go in cycle N -> PSEL in N+1 -> PENABLE in N+2; completes at the first PREADY in ACCESS.
// Backpressure: starts only when the head entry's data (write) or read space (read) is available; PREADY stalls ACCESS.
module apb_master
    import ahb_apb_pkg::*;
#(
    parameter int paddrWidth = 8,
    parameter int pdataWidth = 32,
    parameter int CTRL_W     = 1 + 2 + 3 + 3 + paddrWidth
) (
    input  logic                  PCLK,
    input  logic                  PRESET,

    input  logic                  ctrl_empty,
    input  logic [CTRL_W-1:0]     ctrl_rdata,
    output logic                  ctrl_ren,

    input  logic                  ahb_data_empty,
    input  logic [pdataWidth-1:0] ahb_data_rdata,
    output logic                  ahb_data_ren,

    input  logic                  apb_data_full,
    output logic                  apb_data_wen,
    output logic [pdataWidth-1:0] apb_data_wdata,

    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [paddrWidth-1:0] PADDR,
    output logic [pdataWidth-1:0] PWDATA,
    output logic [3:0]            PSTRB,
    input  logic [pdataWidth-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,

    output logic                  slverr_o
);

    localparam int SIZE_LSB  = paddrWidth;
    localparam int BURST_LSB = paddrWidth + 3;
    localparam int TRANS_MSB = paddrWidth + 7;
    localparam int WRITE_BIT = paddrWidth + 8;

    // Head-of-FIFO ctrl fields; trans/burst carry no meaning here.
    logic                  hd_write;
    logic [2:0]            hd_size;
    logic [paddrWidth-1:0] hd_addr;
    logic [3:0]            hd_pstrb;
    logic                  unused_hd_fields;

    assign hd_write         = ctrl_rdata[WRITE_BIT];
    assign hd_size          = ctrl_rdata[SIZE_LSB+2:SIZE_LSB];
    assign hd_addr          = ctrl_rdata[paddrWidth-1:0];
    assign unused_hd_fields = ^ctrl_rdata[TRANS_MSB:BURST_LSB];

    apb_pstrb_gen u_pstrb_gen (
        .write   (hd_write),
        .size    (hd_size),
        .addr_lo (hd_addr[1:0]),
        .pstrb   (hd_pstrb)
    );

    apb_state_e            state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [paddrWidth-1:0] paddr_q, paddr_d;
    logic [pdataWidth-1:0] pwdata_q, pwdata_d;
    logic [3:0]            pstrb_q, pstrb_d;

    logic go;
    logic load;
    logic ctrl_pop;
    logic wd_pop;
    logic rd_push;
    logic err_pulse;

    // Read space is only checked here: at most one read is ever in flight.
    assign go = !ctrl_empty && (hd_write ? !ahb_data_empty : !apb_data_full);

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        load      = 1'b0;
        rd_push   = 1'b0;
        err_pulse = 1'b0;

        case (state_q)
            P_IDLE: begin
                load = go;
            end
            P_SETUP: begin
                state_d   = P_ACCESS;
                penable_d = 1'b1;
            end
            P_ACCESS: begin
                if (PREADY) begin
                    rd_push   = !pwrite_q;
                    err_pulse = PSLVERR;
                    if (go) begin
                        load = 1'b1;
                    end else begin
                        state_d   = P_IDLE;
                        psel_d    = 1'b0;
                        penable_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d   = P_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase

        // A pop always lands in SETUP, whether from IDLE or back-to-back from ACCESS.
        if (load) begin
            state_d   = P_SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
            pwrite_d  = hd_write;
            paddr_d   = hd_addr;
            pwdata_d  = hd_write ? ahb_data_rdata : '0;
            pstrb_d   = hd_pstrb;
        end

        ctrl_pop = load;
        wd_pop   = load && hd_write;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= P_IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
        end
    end

    // FIFO strobes are combinational; masking by PRESET keeps them quiet while reset is held.
    assign ctrl_ren       = ctrl_pop && !PRESET;
    assign ahb_data_ren   = wd_pop && !PRESET;
    assign apb_data_wen   = rd_push && !PRESET;
    assign apb_data_wdata = apb_data_wen ? PRDATA : '0;
    assign slverr_o       = err_pulse && !PRESET;

    assign PSEL    = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PSTRB   = pstrb_q;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: FIFO and APB completer models, in-order transfer scoreboard, directed then random traffic.
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        ctrl_empty;
    logic [16:0] ctrl_rdata;
    logic        ctrl_ren;
    logic        ahb_data_empty;
    logic [31:0] ahb_data_rdata;
    logic        ahb_data_ren;
    logic        apb_data_full;
    logic        apb_data_wen;
    logic [31:0] apb_data_wdata;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        slverr_o;

    apb_master #(.paddrWidth(8), .pdataWidth(32)) dut (
        .PCLK           (PCLK),
        .PRESET         (PRESET),
        .ctrl_empty     (ctrl_empty),
        .ctrl_rdata     (ctrl_rdata),
        .ctrl_ren       (ctrl_ren),
        .ahb_data_empty (ahb_data_empty),
        .ahb_data_rdata (ahb_data_rdata),
        .ahb_data_ren   (ahb_data_ren),
        .apb_data_full  (apb_data_full),
        .apb_data_wen   (apb_data_wen),
        .apb_data_wdata (apb_data_wdata),
        .PSEL           (PSEL),
        .PENABLE        (PENABLE),
        .PWRITE         (PWRITE),
        .PADDR          (PADDR),
        .PWDATA         (PWDATA),
        .PSTRB          (PSTRB),
        .PRDATA         (PRDATA),
        .PREADY         (PREADY),
        .PSLVERR        (PSLVERR),
        .slverr_o       (slverr_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct packed {
        logic        w;
        logic [2:0]  size;
        logic [7:0]  addr;
        logic [31:0] wd;
    } xfer_t;

    int n_tests = 0;
    int n_fail  = 0;
    int n_cren = 0, n_wren = 0, n_wen = 0, n_slv = 0, n_done = 0, n_access = 0;

    logic [16:0] cq[$];
    logic [31:0] wq[$];
    xfer_t       exp_x[$];
    logic [31:0] exp_rd[$];

    logic        force_full = 0, force_wempty = 0;
    logic        rand_waits = 0, rand_err = 0, use_fixed = 0, err_cfg = 0;
    int          waits_cfg = 0, wait_left = 0;
    logic [31:0] fixed_rd = 0;
    logic        s_cren = 0, s_wren = 0;
    logic        prev_stall = 0;
    logic [46:0] prev_bus = 0;
    logic [3:0]  last_strb = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe expectation from lane arithmetic: naturally aligned group of 2**size bytes.
    function automatic logic [3:0] model_strb(input logic w, input logic [2:0] sz, input logic [7:0] a);
        int lanes;
        int first;
        if (!w) return 4'b0000;
        lanes = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
        first = (lanes == 4) ? 0 : (int'(a[1:0]) / lanes) * lanes;
        return 4'(((1 << lanes) - 1) << first);
    endfunction

    task automatic push_ctrl(input logic w, input logic [2:0] sz, input logic [7:0] a,
                             input logic [31:0] wd, input logic [1:0] tr, input logic [2:0] bu);
        xfer_t x;
        cq.push_back({w, tr, bu, sz, a});
        x.w = w; x.size = sz; x.addr = a; x.wd = wd;
        exp_x.push_back(x);
    endtask

    task automatic drive_inputs();
        ctrl_empty     = (cq.size() == 0);
        ctrl_rdata     = ctrl_empty ? 17'($urandom) : cq[0];
        ahb_data_empty = (wq.size() == 0) || force_wempty;
        ahb_data_rdata = (wq.size() != 0) ? wq[0] : $urandom;
        apb_data_full  = force_full;
        if (PSEL && !PENABLE) wait_left = rand_waits ? int'($urandom_range(0, 3)) : waits_cfg;
        if (PSEL && PENABLE && wait_left > 0) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b1;
            PRDATA  = $urandom;
            wait_left--;
        end else if (PSEL && PENABLE) begin
            PREADY  = 1'b1;
            PRDATA  = use_fixed ? fixed_rd : $urandom;
            PSLVERR = rand_err ? 1'($urandom_range(0, 1)) : err_cfg;
            if (exp_x.size() != 0 && !exp_x[0].w) exp_rd.push_back(PRDATA);
        end else begin
            PREADY  = 1'($urandom_range(0, 1));
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic sample();
        xfer_t e;
        logic  done;
        done = PSEL && PENABLE && PREADY;
        chk("penable_needs_psel", (!PENABLE || PSEL), 1);
        chk("ctrl_pop_nonempty", (ctrl_ren && ctrl_empty), 0);
        chk("wd_pop_nonempty", (ahb_data_ren && ahb_data_empty), 0);
        chk("wd_pop_with_write", ahb_data_ren, (ctrl_ren && cq.size() != 0 && cq[0][16]));
        chk("rd_start_space", (ctrl_ren && cq.size() != 0 && !cq[0][16] && apb_data_full), 0);
        if (prev_stall) chk("stall_stable", {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, prev_bus);
        if (done) begin
            chk("xfer_expected", (exp_x.size() != 0), 1);
            if (exp_x.size() != 0) begin
                e = exp_x.pop_front();
                chk("pwrite", PWRITE, e.w);
                chk("paddr", PADDR, e.addr);
                chk("pstrb", PSTRB, model_strb(e.w, e.size, e.addr));
                if (e.w) chk("pwdata", PWDATA, e.wd);
                chk("rd_push", apb_data_wen, !e.w);
                if (!e.w && exp_rd.size() != 0) chk("rd_data", apb_data_wdata, exp_rd.pop_front());
            end
            chk("slverr_on_done", slverr_o, PSLVERR);
            last_strb = PSTRB;
            n_done++;
        end else begin
            chk("no_push_idle", apb_data_wen, 0);
            chk("no_slverr_idle", slverr_o, 0);
        end
        n_cren   += int'(ctrl_ren);
        n_wren   += int'(ahb_data_ren);
        n_wen    += int'(apb_data_wen);
        n_slv    += int'(slverr_o);
        n_access += int'(PSEL && PENABLE);
        s_cren     = ctrl_ren;
        s_wren     = ahb_data_ren;
        prev_stall = PSEL && PENABLE && !PREADY;
        prev_bus   = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB};
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
        if (s_cren && cq.size() != 0) void'(cq.pop_front());
        if (s_wren && wq.size() != 0) void'(wq.pop_front());
        drive_inputs();
        @(negedge PCLK);
        sample();
    endtask

    task automatic drain(input string tag);
        int k = 0;
        while (k < 200 && !(cq.size() == 0 && exp_x.size() == 0 && !PSEL)) begin
            tick();
            k++;
        end
        chk(tag, (cq.size() == 0 && exp_x.size() == 0 && !PSEL), 1);
    endtask

    task automatic do_one(input logic w, input logic [2:0] sz, input logic [7:0] a, input logic [31:0] wd);
        push_ctrl(w, sz, a, wd, 2'b10, 3'b000);
        if (w) wq.push_back(wd);
        drain("do_one_drain");
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {ctrl_ren, ahb_data_ren, apb_data_wen, apb_data_wdata, slverr_o}, 0);
        chk(tag, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, w0, a0, d0, s0, pushed, k;

        // Reset state
        PRESET = 1'b1;
        drive_inputs();
        repeat (3) tick();
        chk_all_zero("reset_outputs");
        PRESET = 1'b0;
        tick();
        chk("post_reset_idle", PSEL, 0);

        // Single word write: latency and field values
        push_ctrl(1'b1, 3'd2, 8'h10, 32'hDEADBEEF, 2'b10, 3'b000);
        wq.push_back(32'hDEADBEEF);
        tick();
        chk("t1_n_ctrl_ren", ctrl_ren, 1);
        chk("t1_n_wd_ren", ahb_data_ren, 1);
        chk("t1_n_psel", PSEL, 0);
        tick();
        chk("t1_n1_sel_en", {PSEL, PENABLE}, 2'b10);
        chk("t1_n1_paddr", PADDR, 8'h10);
        chk("t1_n1_pwdata", PWDATA, 32'hDEADBEEF);
        chk("t1_n1_pstrb", PSTRB, 4'hF);
        chk("t1_n1_pwrite", PWRITE, 1);
        tick();
        chk("t1_n2_sel_en", {PSEL, PENABLE}, 2'b11);
        tick();
        chk("t1_n3_idle", {PSEL, PENABLE}, 2'b00);

        // Read with two wait states
        waits_cfg = 2; use_fixed = 1; fixed_rd = 32'h12345678;
        w0 = n_wen; a0 = n_access;
        push_ctrl(1'b0, 3'd2, 8'h24, 32'h0, 2'b10, 3'b000);
        tick();
        chk("t2_ctrl_ren", ctrl_ren, 1);
        chk("t2_no_wd_ren", ahb_data_ren, 0);
        repeat (3) tick();
        chk("t2_stall_no_push", apb_data_wen, 0);
        tick();
        chk("t2_push", apb_data_wen, 1);
        chk("t2_push_data", apb_data_wdata, 32'h12345678);
        chk("t2_paddr", PADDR, 8'h24);
        chk("t2_pstrb_read", PSTRB, 4'h0);
        tick();
        chk("t2_idle", PSEL, 0);
        chk("t2_one_push", n_wen - w0, 1);
        chk("t2_access_cycles", n_access - a0, 3);
        waits_cfg = 0; use_fixed = 0;

        // Strobe patterns
        do_one(1'b1, 3'd0, 8'h03, 32'hA5A5A5A5);
        chk("t3_byte_03", last_strb, 4'b1000);
        do_one(1'b1, 3'd1, 8'h02, 32'h5A5A5A5A);
        chk("t3_half_02", last_strb, 4'b1100);
        do_one(1'b1, 3'd1, 8'h01, 32'h01020304);
        chk("t3_half_01", last_strb, 4'b0011);
        do_one(1'b1, 3'd0, 8'h41, 32'h11223344);
        chk("t3_byte_41", last_strb, 4'b0010);
        do_one(1'b0, 3'd0, 8'h03, 32'h0);
        chk("t3_read", last_strb, 4'b0000);

        // Four back-to-back writes, zero wait states
        c0 = n_cren; w0 = n_wren; d0 = n_done;
        for (int i = 0; i < 4; i++) begin
            push_ctrl(1'b1, 3'd2, 8'(8'h40 + 4 * i), 32'hC0DE0000 + i, 2'b10, 3'b001);
            wq.push_back(32'hC0DE0000 + i);
        end
        tick();
        chk("t4_first_pop", ctrl_ren, 1);
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("t4_psel_held", PSEL, 1);
            chk("t4_penable_toggle", PENABLE, (i % 2 == 0));
        end
        chk("t4_ctrl_pops", n_cren - c0, 4);
        chk("t4_wd_pops", n_wren - w0, 4);
        chk("t4_done", n_done - d0, 4);
        tick();
        chk("t4_idle", PSEL, 0);

        // Read blocked by full read-data FIFO
        force_full = 1;
        push_ctrl(1'b0, 3'd2, 8'h80, 32'h0, 2'b10, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_blocked", {ctrl_ren, PSEL}, 2'b00);
        end
        force_full = 0;
        tick();
        chk("t5_pop", {ctrl_ren, PSEL}, 2'b10);
        tick();
        chk("t5_setup", {PSEL, PENABLE}, 2'b10);
        drain("t5_drain");

        // Write blocked by empty write-data FIFO
        push_ctrl(1'b1, 3'd2, 8'h90, 32'hFEEDF00D, 2'b10, 3'b000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_blocked", {ctrl_ren, ahb_data_ren, PSEL}, 3'b000);
        end
        wq.push_back(32'hFEEDF00D);
        tick();
        chk("t6_pop", {ctrl_ren, ahb_data_ren}, 2'b11);
        drain("t6_drain");

        // Error response, PSLVERR held high through the wait cycle as well
        err_cfg = 1; waits_cfg = 1; s0 = n_slv;
        do_one(1'b1, 3'd2, 8'hA0, 32'h0BADF00D);
        chk("t7_one_pulse", n_slv - s0, 1);
        err_cfg = 0;

        // Reset in the middle of ACCESS
        waits_cfg = 5;
        push_ctrl(1'b0, 3'd2, 8'hB4, 32'h0, 2'b10, 3'b000);
        k = 0;
        while (k < 10 && !(PSEL && PENABLE)) begin
            tick();
            k++;
        end
        chk("t8_reached_access", (PSEL && PENABLE), 1);
        #1 PRESET = 1'b1;
        #1;
        chk("t8_async_drop", {PSEL, PENABLE}, 2'b00);
        cq.delete(); wq.delete(); exp_x.delete(); exp_rd.delete();
        wait_left = 0; s_cren = 0; s_wren = 0; prev_stall = 0;
        repeat (2) tick();
        chk_all_zero("t8_in_reset");
        PRESET = 1'b0;
        waits_cfg = 0;
        tick();
        chk("t8_restart_idle", PSEL, 0);
        do_one(1'b1, 3'd2, 8'hC8, 32'h600DCAFE);
        chk("t8_after_reset_strb", last_strb, 4'hF);

        // Randomized traffic with random waits, errors and FIFO backpressure
        rand_waits = 1; rand_err = 1;
        d0 = n_done; pushed = 0;
        for (int c = 0; c < 4000 && !(pushed == 40 && cq.size() == 0 && exp_x.size() == 0 && !PSEL); c++) begin
            if (pushed < 40 && $urandom_range(0, 9) < 3) begin
                logic        w;
                logic [31:0] wd;
                w  = 1'($urandom_range(0, 1));
                wd = $urandom;
                push_ctrl(w, 3'($urandom_range(0, 3)), 8'($urandom), wd, 2'($urandom), 3'($urandom));
                if (w) wq.push_back(wd);
                pushed++;
            end
            force_full   = ($urandom_range(0, 9) < 2);
            force_wempty = ($urandom_range(0, 9) == 0);
            tick();
        end
        force_full = 0; force_wempty = 0;
        chk("rand_drained", (cq.size() == 0 && exp_x.size() == 0 && !PSEL), 1);
        chk("rand_count", n_done - d0, 40);
        chk("rand_rd_consumed", exp_rd.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
# apb_master

Back end of the AHB-to-APB bridge. Pops control beats from the ctrl FIFO and write data from the write-data FIFO, drives one APB transfer at a time, and pushes completed read data into the read-data FIFO. The AHB front end returns that data on HRDATA. The block owns all APB sequencing: SETUP/ACCESS phases, wait states and back-to-back transfers.

## Interface
- paddrWidth, 8, APB/FIFO address width (matches AHB side haddrWidth)
- pdataWidth, 32, data width; must be 32 (PSTRB is 4 bits)
- CTRL_W, 1+2+3+3+paddrWidth, ctrl FIFO entry width, packed MSB→LSB {write, trans, burst, size, addr}

Ports:
- PCLK  in  1  single clock for the block
- PRESET  in  1  asynchronous, active-high reset
- ctrl_empty  in  1  ctrl FIFO empty
- ctrl_rdata  in  CTRL_W  ctrl FIFO head (show-ahead: valid whenever !ctrl_empty)
- ctrl_ren  out  1  pop ctrl FIFO
- ahb_data_empty  in  1  write-data FIFO empty
- ahb_data_rdata  in  pdataWidth  write-data FIFO head (show-ahead)
- ahb_data_ren  out  1  pop write-data FIFO
- apb_data_full  in  1  read-data FIFO full
- apb_data_wen  out  1  push read-data FIFO
- apb_data_wdata  out  pdataWidth  read data payload
- PSEL  out  1  APB select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PADDR  out  paddrWidth  APB address
- PWDATA  out  pdataWidth  APB write data
- PSTRB  out  4  APB write strobes
- PRDATA  in  pdataWidth  APB read data
- PREADY  in  1  APB completer ready
- PSLVERR  in  1  APB error, sampled only with PREADY in ACCESS
- slverr_o  out  1  one-cycle pulse when a transfer completes with PSLVERR=1

## Operation
- FSM states: P_IDLE, P_SETUP, P_ACCESS.
- Start condition `go` requires !ctrl_empty and one of:
  - write entry: !ahb_data_empty
  - read entry: !apb_data_full
- P_IDLE, go=1:
  - assert ctrl_ren; also assert ahb_data_ren for a write.
  - register write/addr/size and the write data.
  - go to P_SETUP.
- P_SETUP: PSEL=1, PENABLE=0. Go to P_ACCESS unconditionally.
- P_ACCESS: PSEL=1, PENABLE=1. While PREADY=0, hold here with all APB outputs stable.
- P_ACCESS, PREADY=1:
  - read: apb_data_wen=1, apb_data_wdata=PRDATA.
  - slverr_o=PSLVERR.
  - if go is true that cycle: pop the next entry and go to P_SETUP (back-to-back, PSEL stays high).
  - otherwise: go to P_IDLE.
- Read space is checked only at start. This block is the sole writer of the read-data FIFO and has at most one read outstanding, so the push cannot overflow.
- Read data is pushed even on PSLVERR. The front end handles HRESP.
- trans and burst fields are ignored. Every ctrl entry is exactly one APB transfer.
- PSTRB (writes only; 0 for reads):
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1],1'b0}
  - size ≥2: 4'b1111
- PADDR is passed through unmodified.
- All APB outputs are registered.

## Timing
- Reset values: all outputs 0, state P_IDLE.
- Reset asserted mid-transfer: PSEL/PENABLE drop asynchronously and the popped entry is discarded. FIFOs are reset by the same PRESET.
- Latency: go seen in cycle N → PSEL=1 in cycle N+1 → PENABLE=1 in cycle N+2 → earliest completion at the end of cycle N+2.
- apb_data_wen rises in the same cycle as the completing PREADY. Data is visible in the FIFO one cycle later.
- Throughput with zero wait states: one transfer per 2 cycles, back-to-back.
- Pop enables pulse only in P_IDLE, or in P_ACCESS together with PREADY=1. They are never asserted while the corresponding FIFO is empty.
- PREADY and PRDATA are ignored outside P_ACCESS.

## Structure
- Shared package ahb_apb_pkg holds:
  - HTRANS/HBURST/HSIZE encodings
  - the packed ctrl_t struct (write, trans, burst, size, addr) used by both ahb_slave and apb_master
  - the P_* state enum
- One natural sub-module: apb_pstrb_gen (combinational size/addr → PSTRB), reusable for byte-lane checks in the AHB front end.

## Test plan
- Single write, ctrl={1,NSEQ,SINGLE,size2,0x10}, wdata=0xDEADBEEF, PREADY=1:
  - PSEL in cycle N+1, PENABLE in cycle N+2
  - PADDR=0x10, PWDATA=0xDEADBEEF, PSTRB=4'hF
  - back to P_IDLE afterwards
- Read at 0x24 with 2 PREADY=0 cycles then PRDATA=0x12345678:
  - APB outputs stable for 3 ACCESS cycles
  - exactly one apb_data_wen, with wdata 0x12345678
- Byte write size0 at addr 0x03: PSTRB=4'b1000. Halfword write at addr 0x02: PSTRB=4'b1100. Any read: PSTRB=0.
- Four queued writes, PREADY always 1:
  - PSEL held high continuously
  - PENABLE toggles every cycle
  - 4 transfers in 8 cycles, 4 ctrl_ren and 4 ahb_data_ren
- Read queued with apb_data_full=1 for 5 cycles: no ctrl_ren and PSEL=0 until full deasserts, then SETUP starts the next cycle.
- Write queued with ahb_data_empty=1: no pop, PSEL stays 0.
- PSLVERR=1 on completion: single slverr_o pulse.
- PRESET asserted during ACCESS: PSEL/PENABLE drop immediately and the FSM restarts in P_IDLE.
